// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I sequencer: opcodes, ALU opcodes,
// FSM states and the datapath mux select encodings.
package mc_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SGE  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_SGEU = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_AND  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_SLL  = 4'h9,
        ALU_SRL  = 4'hA,
        ALU_SRA  = 4'hB,
        ALU_EQ   = 4'hC,
        ALU_NE   = 4'hD
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {A_RS1 = 2'd0, A_OLD_PC = 2'd1, A_PC = 2'd2, A_ZERO = 2'd3} a_sel_e;
    typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} b_sel_e;
    typedef enum logic [1:0] {PC_ALU_C = 2'd0, PC_ALUOUT = 2'd1, PC_ALU_C_CLR = 2'd2} pc_sel_e;
    typedef enum logic [1:0] {WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2} wb_sel_e;

    // SYSTEM is deliberately absent: it is handled separately as the halt opcode
    function automatic logic is_known_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: is_known_opcode = 1'b1;
            default:                                is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU opcode decode for the EX cycle, plus a flag telling
// whether a branch funct3 is a real RV32I condition.
module alu_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_op,
    output logic       br_valid
);

    always_comb begin
        alu_op   = ALU_ADD;
        br_valid = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                case (funct3)
                    3'b000:  alu_op = (opcode == OPC_OP && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OPC_BRANCH: begin
                br_valid = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_EQ;
                    3'b001:  alu_op = ALU_NE;
                    3'b100:  alu_op = ALU_SLT;
                    3'b101:  alu_op = ALU_SGE;
                    3'b110:  alu_op = ALU_SLTU;
                    3'b111:  alu_op = ALU_SGEU;
                    default: begin
                        alu_op   = ALU_EQ;
                        br_valid = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_exec_ctrl.sv
// IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core: owns IR and ALUOUT,
// issues ALU operand selects/opcode and steers PC, register file and data memory.
module mc_exec_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [6:0] HALT_OPCODE = 7'b1110011,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_mem_di,
    input  logic [31:0]      alu_c,
    input  logic             alu_brtkn,
    input  logic             d_mem_ack,
    output logic [31:0]      ir,
    output logic             ir_we,
    output logic [3:0]       alu_op,
    output logic [1:0]       a_sel,
    output logic [1:0]       b_sel,
    output logic [31:0]      aluout,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             d_mem_re,
    output logic             d_mem_we,
    output logic             halted,
    output logic [CNT_W-1:0] num_inst
);

    state_e     state;
    state_e     next_state;
    logic [6:0] opc;
    logic [3:0] dec_op;
    logic       br_valid;
    logic       retire;

    assign opc = ir[6:0];

    alu_op_decode u_alu_op_decode (
        .opcode   (opc),
        .funct3   (ir[14:12]),
        .funct7b5 (ir[30]),
        .alu_op   (dec_op),
        .br_valid (br_valid)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IF: next_state = ST_ID;
            ST_ID: begin
                if (opc == HALT_OPCODE)
                    next_state = ST_HALT;
                else if (is_known_opcode(opc))
                    next_state = ST_EX;
                else
                    next_state = ST_IF;
            end
            ST_EX: begin
                case (opc)
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: next_state = ST_WB;
                    OPC_LOAD, OPC_STORE:                   next_state = ST_MEM;
                    default:                               next_state = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (d_mem_ack)
                    next_state = (opc == OPC_LOAD) ? ST_WB : ST_IF;
            end
            ST_WB:   next_state = ST_IF;
            default: next_state = ST_HALT;
        endcase
    end

    // Halt entry leaves next_state at HALT, so it can never count as a retirement
    assign retire = (next_state == ST_IF) &&
                    (state == ST_ID || state == ST_EX || state == ST_MEM || state == ST_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IF;
            ir       <= '0;
            aluout   <= '0;
            num_inst <= '0;
            halted   <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= (next_state == ST_HALT);
            if (state == ST_IF)
                ir <= i_mem_di;
            if (state == ST_ID || state == ST_EX)
                aluout <= alu_c;
            if (retire)
                num_inst <= num_inst + CNT_W'(1);
        end
    end

    // Gated by rst_n so a reset mid-instruction drops every strobe immediately
    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_ALU_C;
        rf_we    = 1'b0;
        wb_sel   = WB_ALUOUT;
        d_mem_re = 1'b0;
        d_mem_we = 1'b0;
        alu_op   = ALU_ADD;
        a_sel    = A_RS1;
        b_sel    = B_RS2;
        if (rst_n) begin
            case (state)
                ST_IF: begin
                    ir_we = 1'b1;
                    a_sel = A_PC;
                    b_sel = B_FOUR;
                    pc_we = 1'b1;
                end
                ST_ID: begin
                    a_sel = A_OLD_PC;
                    b_sel = B_IMM;
                end
                ST_EX: begin
                    case (opc)
                        OPC_OP: alu_op = dec_op;
                        OPC_OPIMM: begin
                            alu_op = dec_op;
                            b_sel  = B_IMM;
                        end
                        OPC_LOAD, OPC_STORE: b_sel = B_IMM;
                        OPC_BRANCH: begin
                            alu_op = dec_op;
                            pc_we  = alu_brtkn & br_valid;
                            pc_sel = PC_ALUOUT;
                        end
                        OPC_JAL: begin
                            pc_we  = 1'b1;
                            pc_sel = PC_ALUOUT;
                            rf_we  = 1'b1;
                            wb_sel = WB_PC;
                        end
                        OPC_JALR: begin
                            b_sel  = B_IMM;
                            pc_we  = 1'b1;
                            pc_sel = PC_ALU_C_CLR;
                            rf_we  = 1'b1;
                            wb_sel = WB_PC;
                        end
                        OPC_LUI: begin
                            a_sel = A_ZERO;
                            b_sel = B_IMM;
                        end
                        OPC_AUIPC: begin
                            a_sel = A_OLD_PC;
                            b_sel = B_IMM;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    d_mem_re = (opc == OPC_LOAD);
                    d_mem_we = (opc == OPC_STORE);
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = (opc == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
                end
                default: ;
            endcase
        end
    end

endmodule
